// File: rtl/gate_exerciser_if.sv
// rtl/gate_exerciser_if.sv - two-input gate bus between exerciser (master) and gate under test (slave)
interface gate_exerciser_if;
  logic a;
  logic b;
  logic c;

  modport master (output a, output b, input c);
  modport slave  (input a, input b, output c);
endinterface

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - drives all four {a,b} vectors into a gate and checks c against TRUTH_TABLE
// Optional two-flop synchroniser on c: GATE_EXERCISER_SYNC_EN
module gate_exerciser #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  gate_exerciser_if.master         gate,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [3:0]               o_fail_vec,
  output logic [2:0]               o_err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  logic w_c;

`ifdef GATE_EXERCISER_SYNC_EN
  // Two extra hold cycles so the synchronised c reflects the current vector.
  localparam int HOLD = SETTLE_CYCLES + 2;
  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], gate.c};
    end
  end

  assign w_c = r_sync[1];
`else
  localparam int HOLD = SETTLE_CYCLES;
  assign w_c = gate.c;
`endif

  localparam logic [4:0] HOLD_LAST = 5'(HOLD);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [4:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_vec;
  logic [2:0] r_err_count;

  logic       w_mismatch;
  logic [3:0] w_fail_next;
  logic       w_accept;

  always_comb begin
    w_mismatch  = (w_c != TRUTH_TABLE[r_idx]);
    w_fail_next = r_fail_vec | ({3'b000, w_mismatch} << r_idx);
    w_accept    = i_start && (r_state != S_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= 5'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_vec  <= 4'd0;
      r_err_count <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_FINISH: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_vec  <= 4'd0;
            r_err_count <= 3'd0;
            r_idx       <= 2'd0;
            r_cnt       <= 5'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          if (r_cnt == HOLD_LAST) begin
            // Sample edge: record this vector and present the next one.
            r_fail_vec <= w_fail_next;
            if (w_mismatch) begin
              r_err_count <= r_err_count + 3'd1;
            end
            r_cnt <= 5'd0;
            if (r_idx == 2'd3) begin
              r_state <= S_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_fail_next == 4'd0);
              r_idx   <= 2'd0;
              r_a     <= 1'b0;
              r_b     <= 1'b0;
            end else begin
              r_idx      <= r_idx + 2'd1;
              {r_a, r_b} <= r_idx + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
      endcase
    end
  end

  assign gate.a      = r_a;
  assign gate.b      = r_b;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail_vec  = r_fail_vec;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - self-checking bench for gate_exerciser with swappable gate models
module tb_gate_exerciser;

`ifdef GATE_EXERCISER_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int S0    = 2;
  localparam int S1    = 1;
  localparam int HOLD0 = S0 + 1 + EXTRA;
  localparam int HOLD1 = S1 + 1 + EXTRA;
  localparam int LAT0  = 4 * HOLD0;
  localparam int LAT1  = 4 * HOLD1;

  typedef struct {
    int         mode;
    logic [3:0] fv;
    logic [2:0] ec;
    logic       ps;
  } vec_t;

  typedef struct {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       ps;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic start0;
  logic start1;
  int   mode;

  logic       busy0, done0, pass0;
  logic [3:0] fv0;
  logic [2:0] ec0;
  logic       busy1, done1, pass1;
  logic [3:0] fv1;
  logic [2:0] ec1;

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];
  vec_t vt[6];

  always #5 clk = ~clk;

  gate_exerciser_if g0();
  gate_exerciser_if g1();

  // 0 NAND, 1 AND, 2 stuck-1, 3 stuck-0, 4 OR, 5 XOR
  function automatic logic gate_fn(input int m, input logic x, input logic y);
    case (m)
      0:       return ~(x & y);
      1:       return x & y;
      2:       return 1'b1;
      3:       return 1'b0;
      4:       return x | y;
      default: return x ^ y;
    endcase
  endfunction

  always_comb g0.c = gate_fn(mode, g0.a, g0.b);
  always_comb g1.c = gate_fn(mode, g1.a, g1.b);

  gate_exerciser #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(S0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .gate(g0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_fail_vec(fv0), .o_err_count(ec0)
  );

  gate_exerciser #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(S1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .gate(g1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_fail_vec(fv1), .o_err_count(ec1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Called in the cycle after edge E0+n0; returns in the done cycle (or after the bound).
  task automatic watch0(input int n0);
    int   n;
    bit   seen;
    res_t r;
    n    = n0;
    seen = 1'b0;
    while (n <= LAT0 + 5 && !seen) begin
      if (done0) begin
        seen = 1'b1;
      end else begin
        if (n < LAT0) begin
          chk("ab_seq", {30'd0, g0.a, g0.b}, n / HOLD0);
          chk("busy_run", busy0, 1);
        end
        @(negedge clk);
        n++;
      end
    end
    chk("done_latency", n, LAT0);
    if (seen) begin
      chk("busy_in_done", busy0, 0);
      chk("ab_in_done", {g0.a, g0.b}, 0);
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        r = sb.pop_front();
        chk("fail_vec", fv0, r.fv);
        chk("err_count", ec0, r.ec);
        chk("pass", pass0, r.ps);
      end
    end
  endtask

  initial begin
    int n;
    int dcount;
    vt[0] = '{0, 4'b0000, 3'd0, 1'b1};
    vt[1] = '{1, 4'b1111, 3'd4, 1'b0};
    vt[2] = '{2, 4'b1000, 3'd1, 1'b0};
    vt[3] = '{3, 4'b0111, 3'd3, 1'b0};
    vt[4] = '{4, 4'b1001, 3'd2, 1'b0};
    vt[5] = '{5, 4'b0001, 3'd1, 1'b0};

    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_a", g0.a, 0);
    chk("rst_b", g0.b, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_fail_vec", fv0, 0);
    chk("rst_err_count", ec0, 0);

    for (int i = 0; i < 6; i++) begin
      mode = vt[i].mode;
      sb.push_back('{vt[i].fv, vt[i].ec, vt[i].ps});
      pulse_start0();
      watch0(0);
      @(negedge clk);
      chk("done_one_cycle", done0, 0);
      chk("busy_after", busy0, 0);
      chk("pass_held", pass0, vt[i].ps);
    end

    // Reset at E0+5 discards a run with a partial failure pending.
    mode = 3;
    pulse_start0();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ab", {g0.a, g0.b}, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_fail_vec", fv0, 0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    chk("midrst_no_done", dcount, 0);

    // start at E0+4 ignored, then back-to-back start in the done cycle.
    mode = 0;
    sb.push_back('{4'b0000, 3'd0, 1'b1});
    pulse_start0();
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    watch0(4);
    mode = 5;
    sb.push_back('{4'b0001, 3'd1, 1'b0});
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b_ab", {g0.a, g0.b}, 0);
    chk("b2b_busy", busy0, 1);
    chk("b2b_done", done0, 0);
    chk("b2b_pass_clr", pass0, 0);
    watch0(0);
    @(negedge clk);

    // Short settle instance with stuck-at-1 output.
    mode = 2;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n <= LAT1 + 5) begin
      @(negedge clk);
      n++;
    end
    chk("s1_done_latency", n, LAT1);
    chk("s1_fail_vec", fv1, 4'b1000);
    chk("s1_err_count", ec1, 1);
    chk("s1_pass", pass1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus/response engine for two-input combinational gates: on `start`, drives `a`/`b` through all four input combinations, waits a programmable settle time, samples the gate output `c`, and compares it against a parameterised truth table. It sits on the drive side of the two-input gate interface (`a`, `b` in, `c` out) and lets a board- or bench-level harness prove any gate in the library with a single pulse. It reports a per-vector fail mask, an error count, and a registered pass flag.

## Interface
- `TRUTH_TABLE`, default `4'b0111`: expected `c` for vector index `{a,b}`; bit `i` is the expected output for index `i`. The default is NAND.
- `SETTLE_CYCLES`, default `2`: cycles each vector is held before sampling. Legal range is 1..15.
- `clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begins a run when sampled high while the block is not busy.
- `c` input, 1 bit: output of the gate under test.
- `a` output, 1 bit: gate input A, the MSB of the vector index.
- `b` output, 1 bit: gate input B, the LSB of the vector index.
- `busy` output, 1 bit: high while a run is in progress.
- `done` output, 1 bit: one-cycle pulse at the end of a run.
- `pass` output, 1 bit: high when the last run had zero mismatches. Held until the next run starts.
- `fail_vec` output, 4 bits: bit `i` is set if vector `i` mismatched.
- `err_count` output, 3 bits: number of mismatching vectors, 0..4.

## Operation
- **Reset values:** `a=0`, `b=0`, `busy=0`, `done=0`, `pass=0`, `fail_vec=0`, `err_count=0`. State goes to IDLE and the vector index and hold counter clear.
- **States:**
  - IDLE: outputs are quiescent and `a=b=0`.
  - RUN: a vector is being held or sampled.
  - FINISH: one cycle in which `done=1` and `pass` is updated. The block returns to IDLE after this cycle.
- **Start acceptance:**
  - `start` is accepted in IDLE or FINISH.
  - On acceptance, `fail_vec`, `err_count` and `pass` clear, the index goes to 0, the hold counter goes to 0, and the state goes to RUN.
  - `start` during RUN is ignored and has no effect on the run in progress.
- **RUN sequencing:**
  - `{a,b}` equals the vector index, which steps 0, 1, 2, 3.
  - The hold counter counts 0..`SETTLE_CYCLES`.
  - At the edge where the counter equals `SETTLE_CYCLES`, `c` is compared with `TRUTH_TABLE[idx]`. On mismatch, `fail_vec[idx]` is set and `err_count` increments.
  - On that same edge the index advances, or the state goes to FINISH if the index was 3.
- **FINISH:** `done=1` and `pass = (fail_vec_next == 0)`, where `fail_vec_next` includes the last vector's result. `a=b=0`.
- **Saturation:** `err_count` cannot exceed 4 and `fail_vec` bits only set, so no wrap or saturation logic is needed.
- **Reset mid-run:** the reset takes effect on the next edge. No `done` pulse is generated and partial results are discarded.
- **Simultaneous `rst` and `start`:** `rst` wins.

## Timing
- Let E0 be the edge at which `start` is accepted.
- Vector `k` is driven on `a`/`b` from E0+k·(S+1) until E0+(k+1)·(S+1), where S = `SETTLE_CYCLES`.
- `c` is sampled at edge E0+(k+1)·(S+1), the same edge that drives the next vector.
- `busy` is high from E0 until E0+4(S+1). `done` is high for the single cycle after edge E0+4(S+1).
- Total latency from the start edge to `done` is 4(S+1) cycles. With the default S=2, this is 12.
- `fail_vec` and `err_count` update at each sample edge. `pass` is valid from the `done` cycle onward.
- Back-to-back runs: `start` high during the `done` cycle begins a new run with no IDLE gap.

## Configuration
- `GATE_EXERCISER_SYNC_EN`
  - **Defined:** `c` passes through a two-flop synchroniser before comparison. Each vector is held S+3 cycles, the sample edge moves to E0+(k+1)·(S+3), and total latency becomes 4(S+3).
  - **Undefined:** `c` is sampled directly with the timing given above.

## Test plan
- **Correct NAND:** connect a correct NAND model to `c`, leave defaults, pulse `start` at E0. Required: `done` in the cycle after E0+12, `pass=1`, `fail_vec=4'b0000`, `err_count=0`, `busy` low after `done`.
- **AND in place of NAND:** connect `c=a&b` with default `TRUTH_TABLE`. Required: `fail_vec=4'b1111`, `err_count=4`, `pass=0`.
- **Stuck-at-1 output:** hold `c=1`. Required: `fail_vec=4'b1000`, `err_count=1`, `pass=0`. With `SETTLE_CYCLES=1`, `done` follows edge E0+8.
- **Reset mid-run:** assert `rst` for one cycle at E0+5. Required: the cycle after the reset edge shows `a=b=0`, `busy=0`, `fail_vec=0`. No `done` pulse within the following 20 cycles.
- **Start during RUN, then back-to-back:** pulse `start` at E0+4. Required: ignored, with `done` still following E0+12. Then hold `start` high during the `done` cycle. Required: a new run starts immediately, with `{a,b}=00` and `busy=1` on the next cycle.
- **Synchroniser build:** with `GATE_EXERCISER_SYNC_EN` defined and a correct NAND, pulse `start`. Required: `done` follows edge E0+20 and `pass=1`.
